// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction-fetch port 0 (read only) and load/store port 1
// share one synchronous memory through a fixed three-cycle IDLE/ACCESS/RESP sequence.
module mem_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int PRIO_MODE = 0
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state;
    logic   owner;      // 0 = port 0, 1 = port 1
    logic   lat_we;     // latched write flag of the transaction in flight
    logic   last;       // port granted most recently (round-robin pointer)
    logic   grant;      // port that would win if sampled this cycle
    logic   grant_we;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        grant = 1'b0;
        if (PRIO_MODE == 1) begin
            grant = ~req0;
        end else if (req0 && req1) begin
            grant = ~last;
        end else begin
            grant = ~req0;
        end
    end

    assign grant_we = grant & we1;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            owner    <= 1'b0;
            lat_we   <= 1'b0;
            last     <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    if (req0 || req1) begin
                        owner    <= grant;
                        last     <= grant;
                        lat_we   <= grant_we;
                        mem_addr <= grant ? addr1 : addr0;
                        mem_we   <= grant_we;
                        mem_din  <= grant_we ? wdata1 : '0;
                        busy     <= 1'b1;
                        state    <= ACCESS;
                    end else begin
                        mem_we   <= 1'b0;
                        mem_addr <= '0;
                        mem_din  <= '0;
                        busy     <= 1'b0;
                    end
                end

                ACCESS: begin
                    // Address holds into RESP so a synchronous memory can present its read data.
                    mem_we  <= 1'b0;
                    mem_din <= '0;
                    ack0    <= ~owner;
                    ack1    <= owner;
                    state   <= RESP;
                end

                RESP: begin
                    ack0     <= 1'b0;
                    ack1     <= 1'b0;
                    mem_addr <= '0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    mem_we   <= 1'b0;
                    mem_addr <= '0;
                    mem_din  <= '0;
                    ack0     <= 1'b0;
                    ack1     <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Read data arrives from the memory during RESP, so it is gated through rather than registered.
    assign rdata0 = (ack0 && !lat_we) ? mem_dout : '0;
    assign rdata1 = (ack1 && !lat_we) ? mem_dout : '0;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width.
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 Parameter PRIO_MODE, default 0, arbitration mode: 0 = round-robin; 1 = fixed priority, port 0 always wins.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low, with ports named as follows.
REQ-005 clk  input  1  system clock; all state changes on the rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req0  input  1  port 0 (instruction fetch) read request.
REQ-008 addr0  input  ADDR_W  port 0 address.
REQ-009 ack0  output  1  port 0 completion pulse.
REQ-010 rdata0  output  DATA_W  port 0 read data.
REQ-011 req1  input  1  port 1 (load/store) request.
REQ-012 we1  input  1  port 1 write enable: 1 = write, 0 = read.
REQ-013 addr1  input  ADDR_W  port 1 address.
REQ-014 wdata1  input  DATA_W  port 1 write data.
REQ-015 ack1  output  1  port 1 completion pulse.
REQ-016 rdata1  output  DATA_W  port 1 read data.
REQ-017 mem_we  output  1  memory write enable.
REQ-018 mem_addr  output  ADDR_W  memory address.
REQ-019 mem_din  output  DATA_W  memory write data.
REQ-020 mem_dout  input  DATA_W  memory read data; valid no later than one clock after mem_addr is stable.
REQ-021 busy  output  1  high in any state other than IDLE.

Function
REQ-022 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-023 IDLE: with no request, the FSM SHALL stay in IDLE.
REQ-024 IDLE: with any request, the FSM SHALL select a winner and latch its address, write data, write flag and owner; next state is ACCESS.
REQ-025 ACCESS: mem_addr SHALL be the latched address, mem_din the latched write data and mem_we the latched write flag (always 0 for port 0); next state is RESP.
REQ-026 RESP: mem_addr SHALL hold the latched address and mem_we SHALL be 0.
REQ-027 RESP: the owner's ack SHALL be 1 for exactly this cycle; next state is IDLE.
REQ-028 In the RESP cycle of a read, the owner's rdata SHALL equal mem_dout.
REQ-029 The non-owner's rdata SHALL be 0 at all times, and so SHALL the owner's rdata whenever its ack is 0.
REQ-030 Latency SHALL be fixed: a request sampled in IDLE at edge N gives ack high in the cycle after edge N+1; each access occupies 3 cycles.
REQ-031 A requester SHALL hold its req and all request fields stable until its ack.
REQ-032 The arbiter SHALL ignore changes to req and request fields outside IDLE.
REQ-033 A req still high in the IDLE cycle after an ack SHALL be treated as a new transaction.
REQ-034 Round-robin (PRIO_MODE=0): with both requests present, the grant SHALL go to the port not granted last.
REQ-035 Round-robin: a single requester SHALL always win.
REQ-036 Round-robin: the last-granted pointer SHALL update only on a grant.
REQ-037 Fixed priority (PRIO_MODE=1): port 0 SHALL win whenever req0 is high.
REQ-038 When mem_we is 0, mem_din SHALL be driven to 0.
REQ-039 When in IDLE, mem_addr SHALL be driven to 0.
REQ-040 A port 1 write SHALL return ack1 with rdata1 = 0.

Reset
REQ-041 rst_n low SHALL immediately, without waiting for clk, force: state IDLE, ack0 = ack1 = 0, mem_we = 0, busy = 0, all data and address outputs 0, last-granted pointer = port 1 (so port 0 wins the first contention).
REQ-042 Reset asserted in ACCESS or RESP SHALL abandon the transaction with no ack; a write aborted in ACCESS before the edge SHALL not occur.
REQ-043 After rst_n deasserts, the first request SHALL be sampled on the next rising edge.

Verification
REQ-044 Memory preloaded with 0x00 = 0x6C, 0x01 = 0x10; req0 with addr0 = 0x00 -> ack0 two cycles after the grant edge, rdata0 = 0x6C, busy high for 2 cycles, mem_we stays 0.
REQ-045 req1 with we1 = 1, addr1 = 0x20, wdata1 = 0xA5 -> mem_we = 1 for exactly one cycle with mem_addr = 0x20 and ack1; then a port 1 read of 0x20 -> rdata1 = 0xA5.
REQ-046 PRIO_MODE = 0, req0 and req1 (read 0x01) held high continuously from reset -> grants alternate 0, 1, 0, 1; rdata1 = 0x10 on each ack1.
REQ-047 PRIO_MODE = 1, both requests held high -> port 0 is granted every transaction and ack1 never asserts until req0 drops.
REQ-048 rst_n pulsed low during the ACCESS cycle of a write of 0x33 to 0x40 -> mem_we falls immediately, no ack occurs, and a read of 0x40 returns its prior value.
REQ-049 Changing addr0 during ACCESS -> mem_addr is unchanged and rdata0 reflects the originally latched address.
